// File: rtl/tcs_pkg.sv
// Shared types and constants for the TCS3200-class colour meter.
//   state_t    : frame sequencing states
//   FILT_*     : {s2,s3} photodiode filter-select codes
//   ch_to_filt : channel index (0=R,1=G,2=B,3=Clear) to filter code
package tcs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    GATE,
    STORE,
    PUBLISH
  } state_t;

  localparam logic [1:0] FILT_R = 2'b00;
  localparam logic [1:0] FILT_G = 2'b11;
  localparam logic [1:0] FILT_B = 2'b01;
  localparam logic [1:0] FILT_C = 2'b10;

  function automatic logic [1:0] ch_to_filt(input logic [1:0] idx);
    case (idx)
      2'd0:    return FILT_R;
      2'd1:    return FILT_G;
      2'd2:    return FILT_B;
      default: return FILT_C;
    endcase
  endfunction

endpackage

// File: rtl/tcs_edge_sync.sv
// Synchroniser plus rising-edge detector for the asynchronous sensor output.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   din  : asynchronous input
//   rise : registered 1-cycle pulse per synchronised rising edge
// din to rise latency is SYNC_STAGES+1 clocks, so a counter using rise
// updates SYNC_STAGES+1 edges after din is first sampled high.
module tcs_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      last <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      last <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/tcs_color_meter.sv
// Colour-sensor front end: steps the filter select through NUM_CH channels,
// counts sensor edges in a fixed gate window per channel and publishes one
// atomic frame of counts. Single-shot or continuous.
//   clk, rst        : clock, synchronous active-high reset
//   start           : 1-cycle request, begins a frame when idle
//   cont            : restart immediately after each frame
//   scale           : latched onto {s0,s1} at each frame start
//   sensor_out      : asynchronous sensor frequency output
//   s0,s1 / s2,s3   : sensor scaling / filter-select pins
//   oe_n, busy      : sensor output enable (low while busy), frame in progress
//   frame_vld       : 1-cycle pulse, counts/sat updated this cycle
//   counts, sat     : per-channel counts [i*CNT_W +: CNT_W] and saturation flags
module tcs_color_meter
  import tcs_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 500,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont,
  input  logic [1:0]              scale,
  input  logic                    sensor_out,
  output logic                    s0,
  output logic                    s1,
  output logic                    s2,
  output logic                    s3,
  output logic                    oe_n,
  output logic                    busy,
  output logic                    frame_vld,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic [NUM_CH-1:0]       sat
);

  localparam int MAX_WIN = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int WCNT_W  = $clog2(MAX_WIN + 1);
  localparam logic [WCNT_W-1:0] SETTLE_LOAD = WCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WCNT_W-1:0] GATE_LOAD   = WCNT_W'(GATE_CYCLES - 1);
  localparam logic [1:0]        LAST_CH     = 2'(NUM_CH - 1);

  state_t                    state;
  state_t                    next_state;
  logic [WCNT_W-1:0]         wcnt;
  logic [1:0]                ch;
  logic [CNT_W-1:0]          cnt;
  logic [NUM_CH*CNT_W-1:0]   shadow;
  logic [NUM_CH-1:0]         sat_sh;
  logic                      rise;
  logic                      frame_go;
  logic                      enter_settle;
  logic                      enter_gate;

  tcs_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sensor_out),
    .rise (rise)
  );

  // Filter select follows the channel register directly.
  assign {s2, s3} = ch_to_filt(ch);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    frame_go     = 1'b0;
    enter_settle = 1'b0;
    enter_gate   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state   = SETTLE;
          frame_go     = 1'b1;
          enter_settle = 1'b1;
        end
      end
      SETTLE: begin
        if (wcnt == '0) begin
          next_state = GATE;
          enter_gate = 1'b1;
        end
      end
      GATE: begin
        if (wcnt == '0) next_state = STORE;
      end
      STORE: begin
        if (ch == LAST_CH) begin
          next_state = PUBLISH;
        end else begin
          next_state   = SETTLE;
          enter_settle = 1'b1;
        end
      end
      PUBLISH: begin
        if (cont) begin
          next_state   = SETTLE;
          frame_go     = 1'b1;
          enter_settle = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      ch        <= '0;
      cnt       <= '0;
      shadow    <= '0;
      sat_sh    <= '0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      busy      <= 1'b0;
      oe_n      <= 1'b1;
      frame_vld <= 1'b0;
      counts    <= '0;
      sat       <= '0;
    end else begin
      // Window counter: loaded with N-1 on entry so each phase lasts N cycles.
      if (enter_settle) begin
        wcnt <= SETTLE_LOAD;
      end else if (enter_gate) begin
        wcnt <= GATE_LOAD;
      end else if ((state == SETTLE || state == GATE) && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end

      // Clearing on the SETTLE->GATE edge drops an edge seen in the last
      // SETTLE cycle while still counting one seen in the first GATE cycle.
      if (enter_gate) begin
        cnt <= '0;
      end else if (state == GATE && rise && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end

      if (frame_go) begin
        {s0, s1} <= scale;
        ch       <= '0;
        busy     <= 1'b1;
        oe_n     <= 1'b0;
      end

      if (state == STORE) begin
        shadow[int'(ch)*CNT_W +: CNT_W] <= cnt;
        sat_sh[ch]                     <= &cnt;
        if (ch != LAST_CH) ch <= ch + 2'd1;
      end

      frame_vld <= (state == PUBLISH);
      if (state == PUBLISH) begin
        counts <= shadow;
        sat    <= sat_sh;
        if (!cont) begin
          busy <= 1'b0;
          oe_n <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcs_color_meter.sv
module tb_tcs_color_meter;

  localparam int GATE   = 100;
  localparam int SETTLE = 10;
  localparam int CHLEN  = SETTLE + GATE + 1;
  localparam int FRAME  = 4 * CHLEN + 1;
  localparam logic [1:0] CODES [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

  logic clk = 1'b0;
  logic rst, start, start4, cont, sensor, sensor4;
  logic [1:0] scale;

  logic s0, s1, s2, s3, oe_n, busy, frame_vld;
  logic [31:0] counts;
  logic [3:0]  sat;

  logic s0_4, s1_4, s2_4, s3_4, oe_n4, busy4, frame_vld4;
  logic [15:0] counts4;
  logic [3:0]  sat4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0][15:0] cnt;
    logic [3:0]       sat;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int per8 [4] = '{10, 10, 10, 10};
  int per4 = 10;

  always #5 clk = ~clk;

  tcs_color_meter #(
    .NUM_CH(4), .CNT_W(8), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .scale(scale),
    .sensor_out(sensor), .s0(s0), .s1(s1), .s2(s2), .s3(s3), .oe_n(oe_n),
    .busy(busy), .frame_vld(frame_vld), .counts(counts), .sat(sat)
  );

  tcs_color_meter #(
    .NUM_CH(4), .CNT_W(4), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .cont(1'b0), .scale(scale),
    .sensor_out(sensor4), .s0(s0_4), .s1(s1_4), .s2(s2_4), .s3(s3_4), .oe_n(oe_n4),
    .busy(busy4), .frame_vld(frame_vld4), .counts(counts4), .sat(sat4)
  );

  function automatic int filt_idx(input logic [1:0] f);
    case (f)
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic exp_t make_exp(input int pa, input int pb, input int pc,
                                    input int pd, input int maxv);
    exp_t e;
    int pp [4];
    e  = '0;
    pp = '{pa, pb, pc, pd};
    for (int k = 0; k < 4; k++) begin
      int raw;
      raw = GATE / pp[k];
      if (raw >= maxv) begin
        e.cnt[k] = 16'(maxv);
        e.sat[k] = 1'b1;
      end else begin
        e.cnt[k] = 16'(raw);
      end
    end
    return e;
  endfunction

  // Square-wave sensor models; dut8 period follows its selected filter.
  initial begin : sens8
    int ph;
    int p;
    ph = 0;
    sensor = 1'b0;
    forever begin
      @(negedge clk);
      p  = per8[filt_idx({s2, s3})];
      ph = (ph + 1 >= p) ? 0 : ph + 1;
      sensor = (ph < p / 2);
    end
  end

  initial begin : sens4
    int ph;
    ph = 0;
    sensor4 = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1 >= per4) ? 0 : ph + 1;
      sensor4 = (ph < per4 / 2);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start4 = 1'b0; cont = 1'b0; scale = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n got %b want 1", oe_n); end
    checks++; if (counts !== '0) begin errors++; $display("FAIL reset_counts got %h want 0", counts); end
    checks++; if (sat !== '0) begin errors++; $display("FAIL reset_sat got %b want 0", sat); end
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", frame_vld); end
    checks++; if ({s0, s1, s2, s3} !== 4'b0) begin errors++; $display("FAIL reset_pins got %b want 0000", {s0, s1, s2, s3}); end
  endtask

  task automatic test_single_frame();
    int got;
    exp_t e;
    per8 = '{10, 10, 10, 10};
    q8.push_back(make_exp(10, 10, 10, 10, 255));
    pulse_start();
    got = -1;
    for (int i = 0; i < FRAME + 100; i++) begin
      if (i == 0) begin
        checks++; if (busy !== 1'b1 || oe_n !== 1'b0) begin errors++; $display("FAIL t1_busy got busy=%b oe_n=%b want 1/0", busy, oe_n); end
      end
      for (int k = 0; k < 4; k++) begin
        if (i == k * CHLEN + 50) begin
          checks++;
          if ({s2, s3} !== CODES[k]) begin errors++; $display("FAIL t1_filter ch%0d got %b want %b", k, {s2, s3}, CODES[k]); end
        end
      end
      if (frame_vld === 1'b1) begin got = i; break; end
      @(negedge clk);
    end
    checks++; if (got != FRAME) begin errors++; $display("FAIL t1_latency got %0d want %0d", got, FRAME); end
    if (q8.size() == 0) begin errors++; $display("FAIL t1_queue got empty want entry"); end
    else begin
      e = q8.pop_front();
      for (int k = 0; k < 4; k++) begin
        int act, ex;
        act = int'(counts[k*8 +: 8]); ex = int'(e.cnt[k]);
        checks++;
        if (e.sat[k] ? (act != ex) : (act < ex - 1 || act > ex + 1)) begin
          errors++; $display("FAIL t1_count ch%0d got %0d want %0d+-1", k, act, ex);
        end
      end
      checks++; if (sat !== e.sat) begin errors++; $display("FAIL t1_sat got %b want %b", sat, e.sat); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || oe_n !== 1'b1) begin errors++; $display("FAIL t1_idle got busy=%b oe_n=%b want 0/1", busy, oe_n); end
  endtask

  task automatic test_per_channel();
    int got;
    exp_t e;
    per8 = '{5, 20, 50, 4};
    q8.push_back(make_exp(5, 20, 50, 4, 255));
    pulse_start();
    got = -1;
    for (int i = 0; i < FRAME + 100; i++) begin
      if (frame_vld === 1'b1) begin got = i; break; end
      @(negedge clk);
    end
    checks++; if (got != FRAME) begin errors++; $display("FAIL t2_latency got %0d want %0d", got, FRAME); end
    e = q8.pop_front();
    for (int k = 0; k < 4; k++) begin
      int act, ex;
      act = int'(counts[k*8 +: 8]); ex = int'(e.cnt[k]);
      checks++;
      if (act < ex - 1 || act > ex + 1) begin errors++; $display("FAIL t2_count ch%0d got %0d want %0d+-1", k, act, ex); end
    end
    checks++; if (sat !== 4'b0000) begin errors++; $display("FAIL t2_sat got %b want 0000", sat); end
    per8 = '{10, 10, 10, 10};
  endtask

  task automatic test_saturation();
    int periods [2] = '{4, 20};
    for (int f = 0; f < 2; f++) begin
      int got;
      exp_t e;
      per4 = periods[f];
      q4.push_back(make_exp(per4, per4, per4, per4, 15));
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      got = -1;
      for (int i = 0; i < FRAME + 100; i++) begin
        if (frame_vld4 === 1'b1) begin got = i; break; end
        @(negedge clk);
      end
      checks++; if (got != FRAME) begin errors++; $display("FAIL t3_latency f%0d got %0d want %0d", f, got, FRAME); end
      e = q4.pop_front();
      for (int k = 0; k < 4; k++) begin
        int act, ex;
        act = int'(counts4[k*4 +: 4]); ex = int'(e.cnt[k]);
        checks++;
        if (e.sat[k] ? (act != ex) : (act < ex - 1 || act > ex + 1)) begin
          errors++; $display("FAIL t3_count f%0d ch%0d got %0d want %0d", f, k, act, ex);
        end
      end
      checks++; if (sat4 !== e.sat) begin errors++; $display("FAIL t3_sat f%0d got %b want %b", f, sat4, e.sat); end
    end
  endtask

  task automatic test_continuous();
    int nv;
    per8 = '{10, 10, 10, 10};
    for (int f = 0; f < 3; f++) q8.push_back(make_exp(10, 10, 10, 10, 255));
    cont = 1'b1;
    pulse_start();
    nv = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (i == FRAME + 100) start = 1'b1;
      if (i == FRAME + 101) start = 1'b0;
      if (nv == 2 && i == 2 * FRAME + 200) cont = 1'b0;
      if (frame_vld === 1'b1) begin
        exp_t e;
        nv++;
        checks++; if (i != nv * FRAME) begin errors++; $display("FAIL t4_spacing frame%0d got %0d want %0d", nv, i, nv * FRAME); end
        checks++; if (busy !== (nv < 3)) begin errors++; $display("FAIL t4_busy frame%0d got %b want %b", nv, busy, nv < 3); end
        if (q8.size() == 0) begin errors++; $display("FAIL t4_queue frame%0d got empty want entry", nv); end
        else begin
          e = q8.pop_front();
          for (int k = 0; k < 4; k++) begin
            int act, ex;
            act = int'(counts[k*8 +: 8]); ex = int'(e.cnt[k]);
            checks++;
            if (act < ex - 1 || act > ex + 1) begin errors++; $display("FAIL t4_count frame%0d ch%0d got %0d want %0d+-1", nv, k, act, ex); end
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (nv != 3) begin errors++; $display("FAIL t4_frames got %0d want 3", nv); end
    cont = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    per8 = '{10, 10, 10, 10};
    for (int f = 0; f < 3; f++) begin
      int got;
      bit seen;
      q8.push_back(make_exp(10, 10, 10, 10, 255));
      pulse_start();
      got = -1;
      seen = 1'b0;
      for (int i = 0; i < FRAME + 100; i++) begin
        if (f == 1) begin
          if (i == 2 * CHLEN + 50) rst = 1'b1;
          if (i == 2 * CHLEN + 51) begin
            rst = 1'b0;
            q8.delete();
            checks++;
            if (busy !== 1'b0 || oe_n !== 1'b1 || frame_vld !== 1'b0 || counts !== '0 ||
                sat !== '0 || {s0, s1, s2, s3} !== 4'b0) begin
              errors++;
              $display("FAIL t5_reset got busy=%b oe_n=%b vld=%b counts=%h sat=%b pins=%b want 0/1/0/0/0/0",
                       busy, oe_n, frame_vld, counts, sat, {s0, s1, s2, s3});
            end
          end
          if (frame_vld === 1'b1) seen = 1'b1;
        end else if (frame_vld === 1'b1) begin
          got = i;
          break;
        end
        @(negedge clk);
      end
      if (f == 1) begin
        checks++; if (seen) begin errors++; $display("FAIL t5_no_vld got 1 want 0"); end
      end else begin
        exp_t e;
        checks++; if (got != FRAME) begin errors++; $display("FAIL t5_latency f%0d got %0d want %0d", f, got, FRAME); end
        e = q8.pop_front();
        for (int k = 0; k < 4; k++) begin
          int act, ex;
          act = int'(counts[k*8 +: 8]); ex = int'(e.cnt[k]);
          checks++;
          if (act < ex - 1 || act > ex + 1) begin errors++; $display("FAIL t5_count f%0d ch%0d got %0d want %0d+-1", f, k, act, ex); end
        end
      end
    end
  endtask

  task automatic test_scale();
    int got;
    scale = 2'b10;
    pulse_start();
    got = -1;
    for (int i = 0; i < FRAME + 100; i++) begin
      if (i == 100) scale = 2'b01;
      if (i == 50 || i == 300) begin
        checks++; if ({s0, s1} !== 2'b10) begin errors++; $display("FAIL t6_scale_mid i%0d got %b want 10", i, {s0, s1}); end
      end
      if (frame_vld === 1'b1) begin got = i; break; end
      @(negedge clk);
    end
    checks++; if (got != FRAME) begin errors++; $display("FAIL t6_latency got %0d want %0d", got, FRAME); end
    repeat (5) @(negedge clk);
    checks++; if ({s0, s1} !== 2'b10) begin errors++; $display("FAIL t6_scale_idle got %b want 10", {s0, s1}); end
    pulse_start();
    checks++; if ({s0, s1} !== 2'b01) begin errors++; $display("FAIL t6_scale_next got %b want 01", {s0, s1}); end
    for (int i = 0; i < FRAME + 100; i++) begin
      if (frame_vld === 1'b1) break;
      @(negedge clk);
    end
    scale = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_per_channel();
    test_saturation();
    test_continuous();
    test_reset_mid_frame();
    test_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
